// File: rtl/vc_storage_pkg.sv
// Shared victim-cache definitions: geometry defaults and the {valid, dirty, tag}
// entry layout used on the storage read/write ports.
package vc_storage_pkg;

    localparam int VC_NUM_WAYS = 8;
    localparam int VC_WAY_W    = $clog2(VC_NUM_WAYS);
    localparam int VC_TAG_W    = 28;
    localparam int VC_LINE_W   = 128;

    // Tag entry as exchanged with the victim cache controller
    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [VC_TAG_W-1:0] tag;
    } vc_cache_tag_type;

endpackage

// File: rtl/vc_plru_tree.sv
// Tree pseudo-LRU for a fully-associative set. Nodes are heap-numbered 1..NUM_WAYS-1;
// a node bit of 0 points the victim search at its lower half, 1 at its upper half.
// Optional clear_i (VC_FLUSH_EN builds) resets the tree and wins over update_i.
module vc_plru_tree
    import vc_storage_pkg::*;
#(
    parameter  int NUM_WAYS = VC_NUM_WAYS,
    localparam int LVL      = $clog2(NUM_WAYS)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
`ifdef VC_FLUSH_EN
    input  logic           clear_i,
`endif
    input  logic           update_i,
    input  logic [LVL-1:0] way_i,
    output logic [LVL-1:0] victim_o
);

    logic [NUM_WAYS-1:1] plru_q;
    logic [NUM_WAYS-1:1] on_path;
    logic [NUM_WAYS-1:1] away;
    logic [LVL:0]        node;

    // Per node: is it on the path to way_i, and which half points away from way_i
    for (genvar gi = 1; gi < NUM_WAYS; gi++) begin : g_node
        localparam int L = $clog2(gi + 1) - 1;
        logic [LVL:0] path;
        assign path        = {1'b1, way_i} >> (LVL - L);
        assign on_path[gi] = (path == (LVL + 1)'(gi));
        assign away[gi]    = ~way_i[LVL-1-L];
    end

    // Tree state: on an MRU update, every node on the way's path flips away from it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            plru_q <= '0;
`ifdef VC_FLUSH_EN
        end else if (clear_i) begin
            plru_q <= '0;
`endif
        end else if (update_i) begin
            plru_q <= (plru_q & ~on_path) | (away & on_path);
        end
    end

    // Victim search: walk from the root, appending each node bit to the heap index
    always_comb begin
        node = (LVL + 1)'(1);
        for (int l = 0; l < LVL; l++) begin
            node = {node[LVL-1:0], plru_q[node[LVL-1:0]]};
        end
    end

    assign victim_o = node[LVL-1:0];

endmodule

// File: rtl/vc_storage.sv
// Fully-associative tag/data store for the victim cache. Lookup and read are
// combinational; tag/data writes and pLRU updates land on the clock edge, all
// aimed at the way selected before the edge (hit way, else first invalid, else
// pLRU victim). Define VC_FLUSH_EN to add flush_i, which clears every valid,
// dirty and pLRU bit and drops any coincident write or MRU update.
module vc_storage
    import vc_storage_pkg::*;
#(
    parameter  int NUM_WAYS = VC_NUM_WAYS,
    parameter  int TAG_W    = VC_TAG_W,
    parameter  int LINE_W   = VC_LINE_W,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
`ifdef VC_FLUSH_EN
    input  logic              flush_i,
`endif
    input  logic [TAG_W-1:0]  lookup_tag_i,
    input  logic              tag_we_i,
    input  logic              data_we_i,
    input  logic [TAG_W+1:0]  tag_write_i,
    input  logic [LINE_W-1:0] data_write_i,
    input  logic              lru_valid_i,
    output logic [TAG_W+1:0]  tag_read_o,
    output logic [LINE_W-1:0] data_read_o,
    output logic              full_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  sel_way_o
);

    logic [NUM_WAYS-1:0] valid_q;
    logic [NUM_WAYS-1:0] dirty_q;
    logic [NUM_WAYS-1:0] match;
    logic [TAG_W-1:0]    tag_q  [NUM_WAYS];
    logic [LINE_W-1:0]   data_q [NUM_WAYS];
    logic [WAY_W-1:0]    sel_way;
    logic [WAY_W-1:0]    victim;
    logic                flush;
    logic                tag_wr_en;
    logic                data_wr_en;

`ifdef VC_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign tag_wr_en  = tag_we_i  && !flush;
    assign data_wr_en = data_we_i && !flush;

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag_i);

        // The controller never installs a tag that is already live in another way
        a_no_dup_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(tag_wr_en && tag_write_i[TAG_W+1] && (sel_way != WAY_W'(gi)) &&
              valid_q[gi] && (tag_q[gi] == tag_write_i[TAG_W-1:0])));
    end

    assign hit_o  = |match;
    assign full_o = &valid_q;

    // Way selection: lowest hit, else lowest invalid, else pLRU victim
    always_comb begin
        sel_way = victim;
        if (!full_o) begin
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (!valid_q[w]) sel_way = WAY_W'(w);
            end
        end
        if (hit_o) begin
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (match[w]) sel_way = WAY_W'(w);
            end
        end
    end

    assign sel_way_o   = sel_way;
    assign tag_read_o  = {valid_q[sel_way], dirty_q[sel_way], tag_q[sel_way]};
    assign data_read_o = data_q[sel_way];

    // Entry state bits: reset/flush clear them, a tag write (valid=0 too) replaces them
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (tag_we_i) begin
            valid_q[sel_way] <= tag_write_i[TAG_W+1];
            dirty_q[sel_way] <= tag_write_i[TAG_W];
        end
    end

    // Tag and line payload: not reset, only meaningful while the way is valid
    always_ff @(posedge clk_i) begin
        if (tag_wr_en)  tag_q[sel_way]  <= tag_write_i[TAG_W-1:0];
        if (data_wr_en) data_q[sel_way] <= data_write_i;
    end

    vc_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
`ifdef VC_FLUSH_EN
        .clear_i  (flush_i),
`endif
        .update_i (lru_valid_i),
        .way_i    (sel_way),
        .victim_o (victim)
    );

endmodule

// File: tb/tb_vc_storage.sv
// Directed bench for vc_storage (8 ways, 28-bit tags, 128-bit lines).
// Expected values are pushed to a scoreboard queue as each step is driven and
// popped against the DUT outputs #1 later, away from the clock edge.
module tb_vc_storage;
    import vc_storage_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
`ifdef VC_FLUSH_EN
    logic         flush_i;
`endif
    logic [27:0]  lookup_tag_i;
    logic         tag_we_i;
    logic         data_we_i;
    logic [29:0]  tag_write_i;
    logic [127:0] data_write_i;
    logic         lru_valid_i;
    logic [29:0]  tag_read_o;
    logic [127:0] data_read_o;
    logic         full_o;
    logic         hit_o;
    logic [2:0]   sel_way_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [159:0] val;
    } exp_t;

    exp_t sb_q[$];

    vc_storage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
`ifdef VC_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .lookup_tag_i (lookup_tag_i),
        .tag_we_i     (tag_we_i),
        .data_we_i    (data_we_i),
        .tag_write_i  (tag_write_i),
        .data_write_i (data_write_i),
        .lru_valid_i  (lru_valid_i),
        .tag_read_o   (tag_read_o),
        .data_read_o  (data_read_o),
        .full_o       (full_o),
        .hit_o        (hit_o),
        .sel_way_o    (sel_way_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] mk_tag(input logic v, input logic d, input int t);
        vc_cache_tag_type e;
        e.valid = v;
        e.dirty = d;
        e.tag   = 28'(t);
        return e;
    endfunction

    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'(8'h30 + i);
        return {16{b}};
    endfunction

    task automatic push(input string name, input logic [159:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [159:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=%0h required=<queued expectation>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h required=%0h", e.name, obs, e.val);
            end
        end
    endtask

    // Drive a lookup, queue hit/sel/valid expectations, then compare after settling
    task automatic look(input string nm, input int t, input logic eh, input int es, input logic ev);
        lookup_tag_i = 28'(t);
        push({nm, "_hit"},   160'(eh));
        push({nm, "_sel"},   160'(es));
        push({nm, "_valid"}, 160'(ev));
        #1;
        pop_check(160'(hit_o));
        pop_check(160'(sel_way_o));
        pop_check(160'(tag_read_o[29]));
    endtask

    task automatic check1(input string nm, input logic [159:0] obs, input logic [159:0] exp);
        push(nm, exp);
        pop_check(obs);
    endtask

    // Apply write/update enables across one rising edge, return at the next falling edge
    task automatic commit(input logic twe, input logic dwe, input logic lru,
                          input logic [29:0] tw, input logic [127:0] dw);
        tag_we_i     = twe;
        data_we_i    = dwe;
        lru_valid_i  = lru;
        tag_write_i  = tw;
        data_write_i = dw;
        @(posedge clk_i);
        @(negedge clk_i);
        tag_we_i    = 1'b0;
        data_we_i   = 1'b0;
        lru_valid_i = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 8; i++) begin
            look($sformatf("fill%0d", i), 'h10 + i, 1'b0, i, 1'b0);
            commit(1'b1, 1'b1, 1'b1, mk_tag(1'b1, 1'b0, 'h10 + i), pat(i));
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
`ifdef VC_FLUSH_EN
        flush_i      = 1'b0;
`endif
        lookup_tag_i = 28'h123;
        tag_we_i     = 1'b0;
        data_we_i    = 1'b0;
        tag_write_i  = '0;
        data_write_i = '0;
        lru_valid_i  = 1'b0;

        // Outputs held in reset
        @(negedge clk_i);
        look("in_reset", 'h123, 1'b0, 0, 1'b0);
        check1("in_reset_full", 160'(full_o), 160'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);
        look("post_reset", 'h123, 1'b0, 0, 1'b0);
        check1("post_reset_full", 160'(full_o), 160'(0));

        // In-order fill of ways 0..7
        fill_all();
        check1("full_after_fill", 160'(full_o), 160'(1));
        for (int i = 0; i < 8; i++) begin
            look($sformatf("rd%0d", i), 'h10 + i, 1'b1, i, 1'b1);
            check1($sformatf("rd%0d_tag", i), 160'(tag_read_o), 160'(mk_tag(1'b1, 1'b0, 'h10 + i)));
            check1($sformatf("rd%0d_data", i), 160'(data_read_o), 160'(pat(i)));
        end

        // Full miss takes pLRU victim 0; after replacing it the victim is way 4
        look("miss99", 'h99, 1'b0, 0, 1'b1);
        commit(1'b1, 1'b1, 1'b1, mk_tag(1'b1, 1'b0, 'h99), pat(9));
        look("hit99", 'h99, 1'b1, 0, 1'b1);
        check1("hit99_data", 160'(data_read_o), 160'(pat(9)));
        look("miss10", 'h10, 1'b0, 4, 1'b1);

        // Hit swap in place on way 3
        look("hit13", 'h13, 1'b1, 3, 1'b1);
        commit(1'b1, 1'b1, 1'b0, mk_tag(1'b1, 1'b1, 'h50), 128'hA5A5);
        look("gone13", 'h13, 1'b0, 4, 1'b1);
        look("hit50", 'h50, 1'b1, 3, 1'b1);
        check1("hit50_tag", 160'(tag_read_o), 160'(mk_tag(1'b1, 1'b1, 'h50)));
        check1("hit50_data", 160'(data_read_o), 160'(128'hA5A5));

        // Invalidate way 5: not full, next miss goes to way 5
        look("hit15", 'h15, 1'b1, 5, 1'b1);
        commit(1'b1, 1'b0, 1'b0, mk_tag(1'b0, 1'b0, 'h15), '0);
        check1("full_after_inval", 160'(full_o), 160'(0));
        look("miss77", 'h77, 1'b0, 5, 1'b0);
        commit(1'b1, 1'b1, 1'b0, mk_tag(1'b1, 1'b0, 'h77), pat(7));
        check1("full_after_refill", 160'(full_o), 160'(1));

        // Data-only write leaves the tag alone
        look("hit16", 'h16, 1'b1, 6, 1'b1);
        commit(1'b0, 1'b1, 1'b0, mk_tag(1'b0, 1'b1, 'h66), 128'hDEAD);
        look("hit16b", 'h16, 1'b1, 6, 1'b1);
        check1("hit16b_tag", 160'(tag_read_o), 160'(mk_tag(1'b1, 1'b0, 'h16)));
        check1("hit16b_data", 160'(data_read_o), 160'(128'hDEAD));

        // MRU touches steer the victim: touch 4 -> victim 2, touch 2 -> victim 6
        look("touch4", 'h14, 1'b1, 4, 1'b1);
        commit(1'b0, 1'b0, 1'b1, '0, '0);
        look("victim2", 'h88, 1'b0, 2, 1'b1);
        look("touch2", 'h12, 1'b1, 2, 1'b1);
        commit(1'b0, 1'b0, 1'b1, '0, '0);
        look("victim6", 'h88, 1'b0, 6, 1'b1);

        // Reset asserted during a write: write lost, everything invalid
        look("pre_rst50", 'h50, 1'b1, 3, 1'b1);
        tag_we_i     = 1'b1;
        data_we_i    = 1'b1;
        lru_valid_i  = 1'b1;
        tag_write_i  = mk_tag(1'b1, 1'b0, 'hBB);
        data_write_i = pat(11);
        #2 rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        tag_we_i    = 1'b0;
        data_we_i   = 1'b0;
        lru_valid_i = 1'b0;
        check1("midrst_full", 160'(full_o), 160'(0));
        look("midrst50", 'h50, 1'b0, 0, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        look("after_rst_bb", 'hBB, 1'b0, 0, 1'b0);

`ifdef VC_FLUSH_EN
        // Flush with a coincident write: all invalid, write dropped
        fill_all();
        check1("flush_prefull", 160'(full_o), 160'(1));
        lookup_tag_i = 28'hAA;
        flush_i      = 1'b1;
        commit(1'b1, 1'b1, 1'b1, mk_tag(1'b1, 1'b0, 'hAA), pat(12));
        flush_i = 1'b0;
        check1("flush_full", 160'(full_o), 160'(0));
        look("flush_aa", 'hAA, 1'b0, 0, 1'b0);
        look("flush_10", 'h10, 1'b0, 0, 1'b0);
        look("flush_17", 'h17, 1'b0, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_storage.md
Name: vc_storage

Overview:
- Fully-associative tag/data store with tree-pLRU replacement for the victim cache.
- Sits directly downstream of victim_cache_controller and consumes its tag_req/data_req, tag_write/data_write and lru_valid.
- Returns tag_read/data_read and full to the controller.
- Lookup is combinational (register-array read); writes and pLRU updates take effect on the clock edge.

Parameters:
- NUM_WAYS, 8, number of entries; power of two, at least 2.
- TAG_W, 28, tag width; equals TAGMSB_VC-TAGLSB_VC+1.
- LINE_W, 128, cache-line data width; equals the cache_data_type width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lookup_tag_i  in  TAG_W  cpu_req addr[TAGMSB_VC:TAGLSB_VC]
- tag_we_i  in  1  tag write enable (tag_req.we)
- data_we_i  in  1  data write enable (data_req.we)
- tag_write_i  in  TAG_W+2  {valid, dirty, tag} to write
- data_write_i  in  LINE_W  line to write
- lru_valid_i  in  1  mark the selected way as MRU
- tag_read_o  out  TAG_W+2  {valid, dirty, tag} of the selected way
- data_read_o  out  LINE_W  data of the selected way
- full_o  out  1  all ways valid
- hit_o  out  1  a valid way matches lookup_tag_i
- sel_way_o  out  $clog2(NUM_WAYS)  selected way index

Behaviour:
- Reset (asynchronous, rst_ni low):
  - All valid and dirty bits = 0; pLRU bits = 0. Tags and data are not reset.
  - Outputs during reset: hit_o=0, full_o=0, sel_way_o=0, tag_read_o={0,0,tag[0]}.
- Hit detect: match[w] = valid[w] && tag[w]==lookup_tag_i. hit_o = |match.
- Selected way, combinational, by priority:
  1. If hit, the lowest-index matching way.
  2. Else, if not full, the lowest-index invalid way.
  3. Else, the pLRU victim way.
- Read: tag_read_o and data_read_o show the selected way's entry in the same cycle (0-cycle latency). On a miss with an invalid way selected, tag_read_o.valid=0, so the controller reports a miss.
- Write: at posedge, tag_we_i writes tag_write_i into sel_way and data_we_i writes data_write_i into sel_way. The two enables act independently.
  - Hit case (controller swap on COMPARE_TAG hit): the hit entry is overwritten in place with the incoming evicted line.
  - Miss case (UPDATE_VC): the line is inserted into the invalid or victim way.
- pLRU: binary tree of NUM_WAYS-1 bits. On lru_valid_i at posedge, every node on the path to sel_way is set to point away from sel_way. The victim is found by following the node bits from the root.
- full_o = &valid, combinational from registered state.
- Write and lru_valid_i in the same cycle: both use the same pre-edge sel_way.
- Written tag equal to another valid entry's tag: no dedup. The controller guarantees this cannot occur; an SVA asserts it.
- Write with tag_write_i.valid=0 invalidates the way; full_o drops the next cycle.
- Reset asserted mid-write: the write is lost and all entries become invalid.
- NUM_WAYS=2: the tree is 1 bit; the victim is the way opposite the last MRU.

Optional Feature:
- Macro: VC_FLUSH_EN.
- With it: adds input flush_i (1 bit). On a flush_i posedge, all valid bits, dirty bits and pLRU bits are cleared.
  - flush_i has priority over a coincident write or lru update, which are dropped.
  - Dirty lines are discarded; writeback is the caller's responsibility beforehand.
- Without it: no port and no logic.

Decomposition:
- Package cache_def additions: VC_NUM_WAYS, VC_WAY_W=$clog2(VC_NUM_WAYS), and the existing vc_cache_tag_type reused for the tag_read_o/tag_write_i port types.
- Sub-module: vc_plru_tree.
  - Inputs: clk_i, rst_ni, update_i, way_i.
  - Output: victim_o.
  - Parameter: NUM_WAYS.

Test Plan:
- Reset, then lookup_tag_i=0x123 -> hit_o=0, full_o=0, sel_way_o=0, tag_read_o.valid=0.
- Insert tags 0x10..0x17 with tag_we_i, data_we_i and lru_valid_i set in successive cycles -> they fill ways 0..7 in order; full_o=1 after the 8th edge.
- Full set, then lookup 0x99 -> sel_way_o=0 (pLRU victim after in-order fill). Write 0x99 -> way 0 is replaced. Next victim is way 4.
- Lookup 0x13 (way 3), then write {1,1,0x50} with data 0xA5A5 -> way 3 now holds tag 0x50, dirty=1, data 0xA5A5. Lookup 0x13 then misses and lookup 0x50 hits way 3.
- Write {valid=0} to way 5 while full -> full_o=0. The next miss selects way 5 regardless of pLRU.
- With VC_FLUSH_EN: fill 8 entries, pulse flush_i together with tag_we_i -> all invalid, full_o=0, and the coincident write is not applied.
